// File: rtl/dma_mc.sv
// Multi-channel DMA controller: CH_NUM register banks, round-robin channel
// selection and one shared master port running read/write beat pairs.
module dma_mc #(
   parameter int CH_NUM = 4,
   parameter int CNT_W  = 8,
   parameter int AW     = $clog2(CH_NUM) + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     addr,
   input  logic              we,
   input  logic [31:0]       wd,
   output logic [31:0]       rd,
   input  logic [1:0]        size,
   input  logic [CH_NUM-1:0] dma_req,
   output logic              irq,
   output logic              bus_req,
   output logic              bus_lock,
   input  logic              bus_grant,
   output logic [31:0]       addr_m,
   output logic              we_m,
   output logic [31:0]       wd_m,
   output logic [1:0]        size_m,
   input  logic [31:0]       rd_m
);
   localparam int CW = $clog2(CH_NUM);

   typedef enum logic [1:0] {IDLE, REQ, RD, WR} state_t;

   logic [31:0]       cr_q  [CH_NUM];
   logic [31:0]       src_q [CH_NUM];
   logic [31:0]       dst_q [CH_NUM];
   logic [CH_NUM-1:0] pend_q, pend_d, done_q, done_d;
   logic [CW-1:0]     last_q, ch_q, sel_ch, arb_idx, wr_ch;
   logic [1:0]        wr_reg;
   state_t            st_q;
   logic [31:0]       wsrc_q, wdst_q, buf_q;
   logic [1:0]        ssz_q, dsz_q;
   logic              isrc_q, idst_q, abort_q, irq_q, irq_d;
   logic [CNT_W-1:0]  rem_q, sel_len;
   logic              sel_vld, sel_go, abort_now, last_beat, complete;
   logic              unused_size;

   assign unused_size = ^size;
   assign wr_ch  = addr[AW-1:2];
   assign wr_reg = addr[1:0];

   function automatic logic [31:0] step(input logic [1:0] sz);
      case (sz)
         2'b00:   return 32'd1;
         2'b01:   return 32'd2;
         default: return 32'd4;
      endcase
   endfunction

   // Round robin: scan downward so the nearest channel after last_q wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_ch  = last_q;
      arb_idx = last_q;
      for (int k = CH_NUM; k >= 1; k--) begin
         arb_idx = last_q + CW'(k);
         if (pend_q[arb_idx]) begin
            sel_vld = 1'b1;
            sel_ch  = arb_idx;
         end
      end
   end

   assign sel_go    = (st_q == IDLE) && sel_vld;
   assign sel_len   = cr_q[sel_ch][8 +: CNT_W];
   assign abort_now = we && (wr_reg == 2'd0) && (wr_ch == ch_q) && !wd[0] && (st_q != IDLE);
   assign last_beat = (rem_q == CNT_W'(1));
   assign complete  = (st_q == WR) && last_beat && !abort_q && !abort_now;

   always_comb begin
      pend_d = pend_q;
      if (sel_go) pend_d[sel_ch] = 1'b0;
      for (int i = 0; i < CH_NUM; i++)
         if (dma_req[i] && cr_q[i][0]) pend_d[i] = 1'b1;
      if (abort_now) pend_d[ch_q] = 1'b0;
      // A done set in the same cycle as a software clear must win.
      done_d = done_q;
      if (we && (wr_reg == 2'd3) && wd[1]) done_d[wr_ch] = 1'b0;
      if (sel_go && (sel_len == '0)) done_d[sel_ch] = 1'b1;
      if (complete) done_d[ch_q] = 1'b1;
      irq_d = 1'b0;
      for (int i = 0; i < CH_NUM; i++)
         irq_d = irq_d | (done_d[i] & cr_q[i][7]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH_NUM; i++) begin
            cr_q[i]  <= '0;
            src_q[i] <= '0;
            dst_q[i] <= '0;
         end
         pend_q  <= '0;
         done_q  <= '0;
         last_q  <= CW'(CH_NUM - 1);
         ch_q    <= '0;
         st_q    <= IDLE;
         wsrc_q  <= '0;
         wdst_q  <= '0;
         buf_q   <= '0;
         ssz_q   <= '0;
         dsz_q   <= '0;
         isrc_q  <= 1'b0;
         idst_q  <= 1'b0;
         abort_q <= 1'b0;
         rem_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         pend_q <= pend_d;
         done_q <= done_d;
         irq_q  <= irq_d;
         if (we) begin
            case (wr_reg)
               2'd0:    cr_q[wr_ch]  <= wd;
               2'd1:    src_q[wr_ch] <= wd;
               2'd2:    dst_q[wr_ch] <= wd;
               default: ;
            endcase
         end
         if (abort_now) abort_q <= 1'b1;
         case (st_q)
            IDLE: if (sel_vld) begin
               last_q  <= sel_ch;
               ch_q    <= sel_ch;
               wsrc_q  <= src_q[sel_ch];
               wdst_q  <= dst_q[sel_ch];
               ssz_q   <= cr_q[sel_ch][2:1];
               dsz_q   <= cr_q[sel_ch][4:3];
               isrc_q  <= cr_q[sel_ch][5];
               idst_q  <= cr_q[sel_ch][6];
               rem_q   <= sel_len;
               abort_q <= 1'b0;
               if (sel_len != '0) st_q <= REQ;
            end
            REQ: if (bus_grant) st_q <= RD;
            RD: begin
               buf_q <= rd_m >> {wsrc_q[1:0], 3'b000};
               if (isrc_q) wsrc_q <= wsrc_q + step(ssz_q);
               st_q <= WR;
            end
            WR: begin
               if (idst_q) wdst_q <= wdst_q + step(dsz_q);
               rem_q <= rem_q - CNT_W'(1);
               st_q  <= (last_beat || abort_q || abort_now) ? IDLE : RD;
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd = '0;
      case (wr_reg)
         2'd0: rd = cr_q[wr_ch];
         2'd1: rd = src_q[wr_ch];
         2'd2: rd = dst_q[wr_ch];
         default: rd = {29'd0, pend_q[wr_ch], done_q[wr_ch], (st_q != IDLE) && (ch_q == wr_ch)};
      endcase
   end

   assign bus_req  = (st_q == REQ);
   assign bus_lock = (st_q != IDLE);
   assign we_m     = (st_q == WR);
   assign addr_m   = (st_q == WR) ? wdst_q : wsrc_q;
   assign size_m   = (st_q == WR) ? dsz_q : ssz_q;
   assign wd_m     = buf_q << {wdst_q[1:0], 3'b000};
   assign irq      = irq_q;

endmodule
